// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_fetch                                                                |
// | PC owner and 2-entry instruction queue feeding the decoder (valid/ready).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              prog_mem_rd_en,
  output logic [ADDR_W-1:0] prog_mem_addr,
  input  logic [DATA_W-1:0] prog_mem_rdata,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic [DATA_W-1:0] cell_data,
  output logic [ADDR_W-1:0] cell_pc,
  output logic              cell_valid,
  input  logic              cell_ready,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_next;
  logic              w_fetch_ok;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_inflight;

  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_q0_data;
  logic [DATA_W-1:0] r_q1_data;
  logic [ADDR_W-1:0] r_q0_addr;
  logic [ADDR_W-1:0] r_q1_addr;

  logic [1:0]        w_count_next;
  logic [DATA_W-1:0] w_q0_data_next;
  logic [DATA_W-1:0] w_q1_data_next;
  logic [ADDR_W-1:0] w_q0_addr_next;
  logic [ADDR_W-1:0] w_q1_addr_next;

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [2:0]        w_occupancy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:    w_state_next = halt ? S_HALTED : S_RUN;
      S_HALTED: w_state_next = halt ? S_HALTED : S_RUN;
      default:  w_state_next = S_RUN;
    endcase
  end

  // Output logic: HALTED resumes fetching in the very cycle halt drops.
  always_comb begin
    w_fetch_ok = 1'b0;
    case (r_state)
      S_RUN:    w_fetch_ok = !halt;
      S_HALTED: w_fetch_ok = !halt;
      default:  w_fetch_ok = 1'b0;
    endcase
  end

  assign w_pop       = cell_valid && cell_ready;
  assign w_push      = r_inflight && !jump_en;
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
  // Queue slots already claimed (stored + in flight), net of this cycle's pop, must leave room.
  assign w_issue     = !rst && w_fetch_ok && !jump_en &&
                       (w_occupancy < (3'd2 + {2'b00, w_pop}));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_rd_addr  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rd_addr <= r_pc;
      end
      if (jump_en) begin
        r_pc <= jump_addr;
      end else if (w_issue) begin
        r_pc <= r_pc + 1'b1;
      end
    end
  end

  always_comb begin
    w_count_next   = r_count;
    w_q0_data_next = r_q0_data;
    w_q1_data_next = r_q1_data;
    w_q0_addr_next = r_q0_addr;
    w_q1_addr_next = r_q1_addr;
    if (w_pop) begin
      w_q0_data_next = r_q1_data;
      w_q0_addr_next = r_q1_addr;
      w_count_next   = r_count - 2'd1;
    end
    if (w_push) begin
      if (w_count_next == 2'd0) begin
        w_q0_data_next = prog_mem_rdata;
        w_q0_addr_next = r_rd_addr;
      end else begin
        w_q1_data_next = prog_mem_rdata;
        w_q1_addr_next = r_rd_addr;
      end
      w_count_next = w_count_next + 2'd1;
    end
    // A jump discards whatever remains after this cycle's pop.
    if (jump_en) begin
      w_count_next = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= 2'd0;
      r_q0_data <= '0;
      r_q1_data <= '0;
      r_q0_addr <= '0;
      r_q1_addr <= '0;
    end else begin
      r_count   <= w_count_next;
      r_q0_data <= w_q0_data_next;
      r_q1_data <= w_q1_data_next;
      r_q0_addr <= w_q0_addr_next;
      r_q1_addr <= w_q1_addr_next;
    end
  end

  assign prog_mem_rd_en = w_issue;
  assign prog_mem_addr  = r_pc;
  assign pc             = r_pc;
  assign cell_valid     = (r_count != 2'd0);
  assign cell_data      = r_q0_data;
  assign cell_pc        = r_q0_addr;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_fetch                                                             |
// | Directed scenarios plus random traffic against a stream-level model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_instr_fetch;

  localparam int         ADDR_W   = 8;
  localparam int         DATA_W   = 16;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic              clk;
  logic              rst;
  logic              prog_mem_rd_en;
  logic [ADDR_W-1:0] prog_mem_addr;
  logic [DATA_W-1:0] prog_mem_rdata;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              halt;
  logic [DATA_W-1:0] cell_data;
  logic [ADDR_W-1:0] cell_pc;
  logic              cell_valid;
  logic              cell_ready;
  logic [ADDR_W-1:0] pc;

  logic [DATA_W-1:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .prog_mem_rd_en(prog_mem_rd_en),
    .prog_mem_addr (prog_mem_addr),
    .prog_mem_rdata(prog_mem_rdata),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .halt          (halt),
    .cell_data     (cell_data),
    .cell_pc       (cell_pc),
    .cell_valid    (cell_valid),
    .cell_ready    (cell_ready),
    .pc            (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memory, one-cycle read latency
  always @(posedge clk) begin
    if (prog_mem_rd_en) prog_mem_rdata <= mem[prog_mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
  endtask

  // Leaves the bench at cycle 0 (first cycle with rst low), inputs idle.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; jump_en = 1'b0; halt = 1'b0; cell_ready = 1'b0; jump_addr = '0;
    #1;
    check_eq("rst_rd_en", 32'(prog_mem_rd_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_valid", 32'(cell_valid), 32'd0);
    check_eq("rst_pc", 32'(pc), 32'(RESET_PC));
    check_eq("rst_data", 32'(cell_data), 32'd0);
    check_eq("rst_cell_pc", 32'(cell_pc), 32'd0);
  endtask

  // Random-phase model state: stream-level view of the fetch unit
  int         m_outstanding;
  bit         m_prev_issue;
  logic [7:0] m_pc;
  logic [7:0] m_exp_del;
  bit         m_stalled;
  logic [15:0] m_held_data;
  logic [7:0]  m_held_pc;

  initial begin
    rst = 1'b1; jump_en = 1'b0; jump_addr = '0; halt = 1'b0; cell_ready = 1'b0;
    fill_linear();

    // Basic streaming after reset
    apply_reset();
    cell_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_eq("d1_rd_en", 32'(prog_mem_rd_en), 32'd1);
      check_eq("d1_addr", 32'(prog_mem_addr), 32'(c));
      if (c < 2) begin
        check_eq("d1_valid_lo", 32'(cell_valid), 32'd0);
      end else begin
        check_eq("d1_valid", 32'(cell_valid), 32'd1);
        check_eq("d1_cell_pc", 32'(cell_pc), 32'(c - 2));
        check_eq("d1_data", 32'(cell_data), 32'h0100 + 32'(c - 2));
      end
      @(negedge clk);
    end

    // Backpressure from cycle 0, then release
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      cell_ready = (c >= 6);
      #1;
      if (c < 6) begin
        check_eq("d2_rd_en", 32'(prog_mem_rd_en), (c < 2) ? 32'd1 : 32'd0);
        if (c >= 2) begin
          check_eq("d2_hold_valid", 32'(cell_valid), 32'd1);
          check_eq("d2_hold_data", 32'(cell_data), 32'h0100);
        end
      end else begin
        check_eq("d2_valid", 32'(cell_valid), 32'd1);
        check_eq("d2_cell_pc", 32'(cell_pc), 32'(c - 6));
        check_eq("d2_data", 32'(cell_data), 32'h0100 + 32'(c - 6));
        if (c == 6) check_eq("d2_resume_addr", 32'(prog_mem_addr), 32'd2);
      end
      @(negedge clk);
    end

    // Jump in cycle 5 while streaming
    apply_reset();
    cell_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      jump_en   = (c == 5);
      jump_addr = 8'h40;
      #1;
      if (c == 5) begin
        check_eq("d3_rd_en_jump", 32'(prog_mem_rd_en), 32'd0);
        check_eq("d3_pop_pc", 32'(cell_pc), 32'd3);
      end
      if (c == 6) begin
        check_eq("d3_rd_en_tgt", 32'(prog_mem_rd_en), 32'd1);
        check_eq("d3_addr_tgt", 32'(prog_mem_addr), 32'h40);
      end
      if (c == 6 || c == 7) check_eq("d3_valid_lo", 32'(cell_valid), 32'd0);
      if (c == 8) begin
        check_eq("d3_valid", 32'(cell_valid), 32'd1);
        check_eq("d3_cell_pc", 32'(cell_pc), 32'h40);
        check_eq("d3_data", 32'(cell_data), 32'h0140);
      end
      @(negedge clk);
    end
    jump_en = 1'b0;

    // Jump near the top of the address space, PC wraps
    apply_reset();
    cell_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      jump_en   = (c == 0);
      jump_addr = 8'hFE;
      #1;
      if (c == 3) check_eq("d4_pc_wrap", 32'(pc), 32'd0);
      if (c >= 3) begin
        check_eq("d4_valid", 32'(cell_valid), 32'd1);
        check_eq("d4_cell_pc", 32'(cell_pc), 32'((8'hFE + 8'(c - 3)) & 8'hFF));
      end
      @(negedge clk);
    end
    jump_en = 1'b0;

    // Halt for 4 cycles mid-stream
    apply_reset();
    cell_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      halt = (c >= 6 && c <= 9);
      #1;
      if (halt) check_eq("d5_rd_en_halt", 32'(prog_mem_rd_en), 32'd0);
      if (c == 6) check_eq("d5_drain0", 32'(cell_pc), 32'd4);
      if (c == 7) check_eq("d5_drain1", 32'(cell_pc), 32'd5);
      if (c >= 8 && c <= 11) check_eq("d5_valid_lo", 32'(cell_valid), 32'd0);
      if (c == 10) begin
        check_eq("d5_resume_rd", 32'(prog_mem_rd_en), 32'd1);
        check_eq("d5_resume_addr", 32'(prog_mem_addr), 32'd6);
      end
      if (c >= 12) begin
        check_eq("d5_valid", 32'(cell_valid), 32'd1);
        check_eq("d5_cell_pc", 32'(cell_pc), 32'(c - 6));
        check_eq("d5_data", 32'(cell_data), 32'h0100 + 32'(c - 6));
      end
      @(negedge clk);
    end
    halt = 1'b0;

    // Reset with a word queued and a read in flight
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      rst = (c == 2);
      #1;
      if (c == 2) check_eq("d6_rd_en_rst", 32'(prog_mem_rd_en), 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
    cell_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c == 0) check_eq("d6_pc", 32'(pc), 32'(RESET_PC));
      if (c < 2) begin
        check_eq("d6_valid_lo", 32'(cell_valid), 32'd0);
        check_eq("d6_addr", 32'(prog_mem_addr), 32'(c));
      end else begin
        check_eq("d6_cell_pc", 32'(cell_pc), 32'(c - 2));
        check_eq("d6_data", 32'(cell_data), 32'h0100 + 32'(c - 2));
      end
      @(negedge clk);
    end

    // Random traffic against the stream-level model
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    apply_reset();
    m_outstanding = 0; m_prev_issue = 1'b0; m_pc = RESET_PC; m_exp_del = RESET_PC; m_stalled = 1'b0;
    m_held_data = '0; m_held_pc = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit pop;
      bit rd_exp;
      int qcnt;
      rst        = ($urandom_range(0, 199) == 0);
      jump_en    = ($urandom_range(0, 29) == 0);
      jump_addr  = 8'($urandom);
      if ($urandom_range(0, 9) == 0) halt = !halt;
      cell_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (rst) begin
        check_eq("r_rd_en_rst", 32'(prog_mem_rd_en), 32'd0);
        m_outstanding = 0; m_prev_issue = 1'b0; m_pc = RESET_PC; m_exp_del = RESET_PC;
        m_stalled = 1'b0;
      end else begin
        pop    = cell_valid && cell_ready;
        qcnt   = m_outstanding - int'(m_prev_issue);
        rd_exp = !halt && !jump_en && ((m_outstanding - int'(pop)) < 2);
        check_eq("r_valid", 32'(cell_valid), (qcnt > 0) ? 32'd1 : 32'd0);
        check_eq("r_pc", 32'(pc), 32'(m_pc));
        check_eq("r_rd_en", 32'(prog_mem_rd_en), 32'(rd_exp));
        if (rd_exp) check_eq("r_addr", 32'(prog_mem_addr), 32'(m_pc));
        if (m_stalled) begin
          check_eq("r_stable_data", 32'(cell_data), 32'(m_held_data));
          check_eq("r_stable_pc", 32'(cell_pc), 32'(m_held_pc));
        end
        if (pop) begin
          check_eq("r_del_pc", 32'(cell_pc), 32'(m_exp_del));
          check_eq("r_del_data", 32'(cell_data), 32'(mem[m_exp_del]));
          m_exp_del = m_exp_del + 8'd1;
        end
        m_stalled   = cell_valid && !cell_ready && !jump_en;
        m_held_data = cell_data;
        m_held_pc   = cell_pc;
        if (jump_en) begin
          m_outstanding = 0; m_prev_issue = 1'b0; m_pc = jump_addr; m_exp_del = jump_addr;
        end else begin
          m_outstanding = m_outstanding - int'(pop) + int'(rd_exp);
          m_prev_issue  = rd_exp;
          if (rd_exp) m_pc = m_pc + 8'd1;
        end
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
